// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads the ROM word at the sampled PC, looks up its branch target,
// and runs the program through an idle/run/halt Start-Done handshake.
module instr_fetch #(
    parameter int                 PC_W        = 10,
    parameter int                 INSTR_W     = 9,
    parameter int                 LUT_IDX_W   = 5,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = 9'h1FF
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [PC_W-1:0]    ProgCtr,
    input  logic               LdEn,
    input  logic               LdLut,
    input  logic [PC_W-1:0]    LdAddr,
    input  logic [PC_W-1:0]    LdData,
    output logic [INSTR_W-1:0] Instruction,
    output logic               InstrValid,
    output logic [PC_W-1:0]    Target,
    output logic               Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [INSTR_W-1:0] rom [0:(1<<PC_W)-1];
    logic [PC_W-1:0]    lut [0:(1<<LUT_IDX_W)-1];

    logic [INSTR_W-1:0] fetch_p0;
    logic [PC_W-1:0]    tgt_p0;
    logic               halt_p0;

    logic [INSTR_W-1:0] instr_d, instr_p1;
    logic [PC_W-1:0]    tgt_d, tgt_p1;
    logic               vld_d, vld_p1;
    logic               done_d, done_p1;

    // Memories carry no reset so a reset mid-run keeps the loaded program.
    always_ff @(posedge Clk) begin
        if (state_q == IDLE && LdEn) begin
            if (LdLut)
                lut[LdAddr[LUT_IDX_W-1:0]] <= LdData;
            else
                rom[LdAddr] <= LdData[INSTR_W-1:0];
        end
    end

    // Stage p0: combinational ROM read chained into the target LUT
    assign fetch_p0 = rom[ProgCtr];
    assign tgt_p0   = lut[fetch_p0[LUT_IDX_W-1:0]];
    assign halt_p0  = (fetch_p0 == HALT_OPCODE);

    // Stage p1: state and registered outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            instr_p1 <= '0;
            tgt_p1   <= '0;
            vld_p1   <= 1'b0;
            done_p1  <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_p1 <= instr_d;
            tgt_p1   <= tgt_d;
            vld_p1   <= vld_d;
            done_p1  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start && !LdEn) state_d = RUN;
            RUN: begin
                // A halt fetch wins over Start falling on the same edge.
                if (halt_p0)     state_d = HALT;
                else if (!Start) state_d = IDLE;
            end
            HALT:    if (!Start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_d = instr_p1;
        tgt_d   = tgt_p1;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            RUN: begin
                if (halt_p0 || Start) begin
                    instr_d = fetch_p0;
                    tgt_d   = tgt_p0;
                    vld_d   = 1'b1;
                    done_d  = halt_p0;
                end
            end
            HALT:    done_d = Start;
            default: ;
        endcase
    end

    assign Instruction = instr_p1;
    assign Target      = tgt_p1;
    assign InstrValid  = vld_p1;
    assign Done        = done_p1;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Read-side partner of the program counter. Samples the PC value each cycle and returns the addressed instruction from an internal loadable instruction ROM.
- Also returns the branch target that the program counter consumes on its Target input, looked up from a loadable branch-target LUT.
- Sequences program execution with a Start/Done handshake: idle, run, halt.
- Sits between the program counter and the decoder/ALU path of the top-level CPU.

Parameters:
- PC_W, 10, program counter / ROM address width (ROM depth 2**PC_W)
- INSTR_W, 9, instruction width
- LUT_IDX_W, 5, branch-target LUT index width, taken from the fetched instruction's LSBs
- HALT_OPCODE, 9'h1FF, instruction encoding that terminates the program

Ports:
- Clk  input  1  clock; all state updates on the rising edge
- Reset  input  1  asynchronous, active-low reset
- Start  input  1  level request to run the loaded program
- ProgCtr  input  PC_W  current program counter value
- LdEn  input  1  load strobe; honoured only in IDLE
- LdLut  input  1  load target select: 0 = instruction ROM, 1 = branch-target LUT
- LdAddr  input  PC_W  load address; LUT loads use only LdAddr[LUT_IDX_W-1:0]
- LdData  input  PC_W  load data; ROM loads use only LdData[INSTR_W-1:0]
- Instruction  output  INSTR_W  registered fetched instruction
- InstrValid  output  1  Instruction/Target hold a fetch of the current run
- Target  output  PC_W  registered LUT entry indexed by the fetched instruction's low LUT_IDX_W bits
- Done  output  1  program reached HALT_OPCODE; held until Start falls

Behaviour:
- Reset asserted (Reset=0), asynchronously:
  - state <= IDLE
  - Instruction=0, InstrValid=0, Target=0, Done=0
  - ROM and LUT contents are NOT cleared; a reset mid-run preserves the loaded program.
- States: IDLE, RUN, HALT.
- IDLE:
  - InstrValid=0, Done=0; Instruction and Target hold their last values.
  - LdEn=1 writes LdData into ROM[LdAddr] (LdLut=0) or LUT[LdAddr[LUT_IDX_W-1:0]] (LdLut=1) at the clock edge.
  - Start=1 with LdEn=0 -> RUN next edge.
  - Start=1 with LdEn=1 -> the load executes; stay in IDLE.
- RUN, at each edge:
  - Instruction <= ROM[ProgCtr]; Target <= LUT[ROM[ProgCtr][LUT_IDX_W-1:0]]; InstrValid <= 1.
  - Latency is exactly one cycle from the ProgCtr value sampled at an edge to the outputs.
  - The first valid output appears one edge after entering RUN.
  - LdEn is ignored; memories are unchanged.
- RUN, halt and abort:
  - If the fetched ROM word equals HALT_OPCODE: HALT next edge. On that same edge Instruction <= HALT_OPCODE, InstrValid <= 1, Done <= 1.
  - Start falling in RUN -> IDLE next edge; InstrValid <= 0; no Done.
  - If Start falls on the same edge as a halt fetch, halt wins: go to HALT, Done=1, then drop to IDLE on the following edge.
- HALT:
  - Done=1, InstrValid=0; Instruction and Target frozen; LdEn ignored.
  - Start=0 -> IDLE next edge, Done <= 0.
  - Start held high keeps HALT indefinitely; no automatic re-run.
- PC wrap: ProgCtr spans the full ROM depth, so there is no out-of-range address. Going from 2**PC_W-1 to 0 is just a normal fetch.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive Reset=0 mid-cycle with arbitrary inputs -> Instruction=0, Target=0, InstrValid=0, Done=0 immediately, without waiting for a clock edge.
- Load then fetch:
  - Load ROM[0]=9'h012, ROM[1]=9'h034 and LUT[5'h14]=10'd100; release Reset; Start=1; ProgCtr=0.
  - Expect InstrValid=1, Instruction=9'h012 one edge after RUN entry.
  - ProgCtr=1 -> next edge Instruction=9'h034, Target=100.
- Halt handshake:
  - Load ROM[2]=9'h1FF; run to ProgCtr=2.
  - Next edge: Done=1, Instruction=9'h1FF. Done stays 1 for 5 cycles with Start=1.
  - Drop Start -> next edge Done=0, state IDLE.
- Load lockout: in RUN, pulse LdEn with LdAddr=0, LdData=9'h0AA -> later fetch of PC 0 still returns 9'h012.
- Reset mid-run: assert Reset during RUN at ProgCtr=1 -> outputs cleared. Release, Start=1, ProgCtr=1 -> Instruction=9'h034, proving ROM contents are retained.
- Abort and same-edge halt:
  - Start falls in RUN at a non-halt PC -> IDLE next edge, InstrValid=0, Done never asserts.
  - Start falls on the halt-fetch edge -> Done=1 for exactly one cycle.
